// File: rtl/median_pkg.sv
// median_pkg: state encoding and window geometry shared by the 7x7 median pipeline stages.
package median_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} wr_state_e;
  localparam int IMG_W     = 64;
  localparam int IMG_H     = 64;
  localparam int OUT_W_DEF = IMG_W - 7 + 1;
  localparam int OUT_H_DEF = IMG_H - 7 + 1;
endpackage

// File: rtl/median_7_to_bram_writer_if.sv
// median_7_to_bram_writer_if: strobe/median inputs and BRAM write port of the median writer.
interface median_7_to_bram_writer_if #(parameter int DATA_W = 8, parameter int ADDR_W = 12);
  logic              start;
  logic              enable_7x7;
  logic [DATA_W-1:0] median;
  logic              bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_din;
  logic              busy;
  logic              frame_done;
  logic              overrun;
  logic [1:0]        state;
  modport master (output start, enable_7x7, median,
                  input bram_we, bram_addr, bram_din, busy, frame_done, overrun, state);
  modport slave  (input start, enable_7x7, median,
                  output bram_we, bram_addr, bram_din, busy, frame_done, overrun, state);
endinterface

// File: rtl/median_valid_delay.sv
// median_valid_delay: LAT-deep 1-bit shift register aligning the compute strobe with the median result.
module median_valid_delay #(parameter int LAT = 4) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);
  logic [LAT-1:0] sr_q, sr_d;
  always_comb begin
    sr_d    = sr_q << 1;
    sr_d[0] = i_d;
  end
  always_ff @(posedge i_clk) sr_q <= i_rst_n ? sr_d : '0;
  assign o_q = sr_q[LAT-1];
endmodule

// File: rtl/median_7_to_bram_writer.sv
// median_7_to_bram_writer: writes aligned median pixels to BRAM in raster order and flags frame completion.
module median_7_to_bram_writer
  import median_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int MEDIAN_LAT = 4,
  parameter int OUT_W      = OUT_W_DEF,
  parameter int OUT_H      = OUT_H_DEF,
  parameter int ADDR_W     = 12,
  parameter int BASE_ADDR  = 0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  median_7_to_bram_writer_if.slave bus
);
  localparam int CW = $clog2(OUT_W + 1);
  localparam int RW = $clog2(OUT_H + 1);
  localparam logic [CW-1:0]     COL_LAST = CW'(OUT_W - 1);
  localparam logic [RW-1:0]     ROW_LAST = RW'(OUT_H - 1);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  wr_state_e         state_q, state_d;
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [ADDR_W-1:0] addr_q, addr_d, wa_q, wa_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              we_q, we_d, ovr_q, ovr_d, v_al, col_end;
  median_valid_delay #(.LAT(MEDIAN_LAT)) u_dly (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(bus.enable_7x7), .o_q(v_al)
  );
  assign col_end = col_q == COL_LAST;
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    addr_d  = addr_q;
    wa_d    = wa_q;
    din_d   = din_q;
    we_d    = 1'b0;
    ovr_d   = ovr_q;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = RUN;
        col_d   = '0;
        row_d   = '0;
        addr_d  = BASE;
        ovr_d   = 1'b0;
      end
      RUN: if (v_al) begin
        we_d    = 1'b1;
        wa_d    = addr_q;
        din_d   = bus.median;
        addr_d  = addr_q + ADDR_W'(1);
        col_d   = col_end ? '0 : col_q + CW'(1);
        row_d   = col_end ? row_q + RW'(1) : row_q;
        state_d = (col_end && row_q == ROW_LAST) ? DONE : RUN;
      end
      default: state_d = IDLE;
    endcase
    // a valid outside RUN is lost; setting wins over the start-time clear
    if (v_al && state_q != RUN) ovr_d = 1'b1;
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      addr_q  <= BASE;
      wa_q    <= BASE;
      din_q   <= '0;
      we_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      addr_q  <= addr_d;
      wa_q    <= wa_d;
      din_q   <= din_d;
      we_q    <= we_d;
      ovr_q   <= ovr_d;
    end
  end
  assign bus.bram_we    = we_q;
  assign bus.bram_addr  = wa_q;
  assign bus.bram_din   = din_q;
  assign bus.busy       = state_q == RUN;
  assign bus.frame_done = state_q == DONE;
  assign bus.overrun    = ovr_q;
  assign bus.state      = state_q;
endmodule

// File: tb/tb_median_7_to_bram_writer.sv
// tb_median_7_to_bram_writer: directed and random stimulus checked against a frame-level pixel-count model.
module tb_median_7_to_bram_writer;
  localparam int LAT = 2, W = 4, H = 3, BASE = 16;
  logic clk = 1'b0, rst_n = 1'b0;
  int nvec = 0, nerr = 0;
  median_7_to_bram_writer_if #(.DATA_W(8), .ADDR_W(12)) bus ();
  median_7_to_bram_writer #(
    .DATA_W(8), .MEDIAN_LAT(LAT), .OUT_W(W), .OUT_H(H), .ADDR_W(12), .BASE_ADDR(BASE)
  ) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  logic [LAT-1:0] en_hist = '0;
  logic [7:0]     pix_hist [LAT];
  int             mode = 0, cnt = 0;
  logic           m_we = 0, m_ovr = 0;
  int             m_addr = BASE;
  logic [7:0]     m_din = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s @%0t got %0h exp %0h", tag, $time, got, exp);
    end
  endtask
  task automatic step(input logic rn, input logic st, input logic en, input logic [7:0] px);
    logic       va;
    logic [7:0] med;
    int         old;
    va  = en_hist[LAT-1];
    med = va ? pix_hist[LAT-1] : 8'($urandom);
    rst_n = rn;
    bus.start = st;
    bus.enable_7x7 = en;
    bus.median = med;
    @(posedge clk);
    m_we = 1'b0;
    if (!rn) begin
      mode = 0; cnt = 0; m_ovr = 0; m_addr = BASE; m_din = 0; en_hist = '0;
    end else begin
      old = mode;
      if (old == 0 && st) begin
        mode = 1; cnt = 0; m_ovr = 0;
      end
      if (old == 1 && va) begin
        m_we = 1'b1; m_addr = BASE + cnt; m_din = med; cnt++;
        if (cnt == W * H) mode = 2;
      end
      if (old == 2) mode = 0;
      if (va && old != 1) m_ovr = 1'b1;
      for (int i = LAT - 1; i > 0; i--) pix_hist[i] = pix_hist[i-1];
      pix_hist[0] = px;
      en_hist = {en_hist[LAT-2:0], en};
    end
    #1;
    check("we", 32'(bus.bram_we), 32'(m_we));
    check("addr", 32'(bus.bram_addr), 32'(m_addr));
    check("din", 32'(bus.bram_din), 32'(m_din));
    check("busy", 32'(bus.busy), 32'(mode == 1));
    check("done", 32'(bus.frame_done), 32'(mode == 2));
    check("overrun", 32'(bus.overrun), 32'(m_ovr));
    check("state", 32'(bus.state), 32'(mode));
  endtask
  task automatic idle(input int n);
    repeat (n) step(1'b1, 1'b0, 1'b0, 8'($urandom));
  endtask
  task automatic strobes(input int n, input int maxgap, input int pix0);
    for (int k = 0; k < n; k++) begin
      step(1'b1, 1'b0, 1'b1, 8'(pix0 + k));
      if (maxgap > 0) idle($urandom_range(0, maxgap));
    end
  endtask
  initial begin
    bus.start = 0; bus.enable_7x7 = 0; bus.median = 0;
    for (int i = 0; i < LAT; i++) pix_hist[i] = 0;
    repeat (3) step(1'b0, 1'b0, 1'b1, 8'hAA);
    step(1'b1, 1'b1, 1'b0, 8'h00);
    strobes(W * H, 0, 0);
    idle(LAT + 3);
    step(1'b1, 1'b1, 1'b0, 8'h00);
    strobes(W * H, 4, 8'h40);
    idle(LAT + 3);
    strobes(1, 0, 8'h77);
    idle(LAT + 3);
    step(1'b1, 1'b1, 1'b0, 8'h00);
    idle(2);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    strobes(1, 0, 8'h5A);
    idle(2);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    idle(LAT + 3);
    strobes(1, 0, 8'h33);
    idle(LAT - 1);
    step(1'b1, 1'b1, 1'b0, 8'h00);
    strobes(W * H, 2, 8'h80);
    idle(LAT + 3);
    step(1'b1, 1'b1, 1'b0, 8'h00);
    strobes(5, 1, 8'h10);
    step(1'b1, 1'b1, 1'b1, 8'h15);
    strobes(1, 0, 8'h16);
    idle(LAT + 1);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    idle(3);
    step(1'b1, 1'b1, 1'b0, 8'h00);
    strobes(W * H, 1, 8'hC0);
    idle(LAT + 3);
    repeat (1500) begin
      if ($urandom_range(0, 199) == 0) step(1'b0, 1'b0, 1'($urandom), 8'($urandom));
      else step(1'b1, $urandom_range(0, 15) == 0, 1'($urandom), 8'($urandom));
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
